conv_2by2_addr_sequencer: RTL and testbench
===========================================

CONV_2BY2_ADDR_SEQUENCER -- requirements
Module: conv_2by2_addr_sequencer

Interface
REQ-001 Parameter: ADDR_W, 8, width of all array/filter address outputs.
REQ-002 Parameter: ZERO_ADDR, 25, address of the zero-valued word fed as padding/bubble.
REQ-003 Parameter: FILTER_BASE, 24, address of filter element b00; filter stored in descending order from FILTER_BASE.
REQ-004 Port: clk  input  1  sole clock, all state on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle request to run one full 2x2 convolution sequence.
REQ-007 Port: hold  input  1  stall; freezes sequence while high.
REQ-008 Port: input_array_addr_out  output  ADDR_W  drives input_array_addr_in_2by2 of the 2x2 convolution module.
REQ-009 Port: filter_first_addr_out  output  ADDR_W  drives filter_ceiling_first_array_addr_in_2by2.
REQ-010 Port: filter_second_addr_out  output  ADDR_W  drives filter_ceiling_second_array_addr_in_2by2.
REQ-011 Port: buffer_read_addr_out  output  2  drives buffer_read_addr_in_2by2.
REQ-012 Port: buffer_read_valid  output  1  high when buffer_read_addr_out selects a valid C result.
REQ-013 Port: sys_2by2_en_out  output  1  drives sys_2by2_en.
REQ-014 Port: busy  output  1  high from accepted start until done cycle inclusive.
REQ-015 Port: done  output  1  one-cycle pulse on the cycle after sequence step 24.

Function
REQ-016 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after step 24 issued; DONE->IDLE unconditionally next cycle.
REQ-017 Step counter c runs 0..24 (25 steps) in RUN; all outputs registered; step 0 appears on outputs the cycle after start is sampled.
REQ-018 Filter map f(k), k=0..10: ZERO_ADDR if k mod 4 == 3, else FILTER_BASE - (k - k/4) (integer division); yields 24,23,22,Z,21,20,19,Z,18,17,16.
REQ-019 input_array_addr_out: c for c=0..11; c-8 for c=12..23; ZERO_ADDR for c=24.
REQ-020 filter_first_addr_out: f(c) for c=0..10; ZERO_ADDR for c>=11.
REQ-021 filter_second_addr_out: f(c-13) for c=13..23; ZERO_ADDR otherwise (one-cycle systolic skew vs. input restart at c=12).
REQ-022 buffer_read_addr_out/valid: 0/1 at c=10, 1/1 at c=11, 2/1 at c=23, 3/1 at c=24; otherwise addr holds last value, valid 0.
REQ-023 sys_2by2_en_out = 1 in RUN with hold low; 0 in IDLE, DONE, or when hold high.
REQ-024 hold high in RUN: counter and all address outputs frozen, buffer_read_valid forced 0; resume from same step when hold drops; hold ignored in IDLE/DONE.
REQ-025 start while busy ignored (no restart, no queueing); start in DONE cycle ignored.
REQ-026 Address arithmetic unsigned ADDR_W bits; ZERO_ADDR and FILTER_BASE must be < 2^ADDR_W, no wrap required.

Reset
REQ-027 rst forces IDLE, c=0, all address outputs = ZERO_ADDR, buffer_read_addr_out=0, buffer_read_valid=0, sys_2by2_en_out=0, busy=0, done=0.
REQ-028 rst mid-RUN aborts sequence the next edge with no done pulse; start sampled with rst high ignored.

Structure
REQ-029 Shared package conv_2by2_pkg holds ZERO_ADDR/FILTER_BASE defaults, LAST_STEP=24, phase-2 input restart step 12, filter-2 start step 13, and the state enum.
REQ-030 One combinational sub-module conv_filter_addr_map implements f(k), instantiated twice (first and second ceiling).

Verification
REQ-031 rst 2 cycles, start pulse -> outputs step 0: input 0, filter1 24, filter2 25, en 1; step 3: filter1 25; step 24: input 25, buffer addr 3 valid 1; done pulse next cycle, busy low after.
REQ-032 Full run trace compared cycle-by-cycle against the table of REQ-019..022 (e.g. step 12 input 4, step 13 filter2 24, step 23 input 15 filter2 16 buffer 2).
REQ-033 hold high 3 cycles at step 6 -> outputs frozen at input 6/filter1 19, en 0, then step 7 (filter1 25) follows release; total run 28 cycles.
REQ-034 start re-pulsed at step 5 and in DONE cycle -> ignored; exactly one done per accepted start.
REQ-035 rst asserted at step 15 -> next cycle all addresses 25, en 0, busy 0, no done; new start afterwards yields clean step 0.
REQ-036 Back-to-back: start in first IDLE cycle after done -> second sequence identical to first.

Source files
------------

// File: rtl/conv_2by2_pkg.sv
// Shared constants and state type for the 2x2 convolution address sequencer.
package conv_2by2_pkg;

    // Default location of the zero word and of filter element b00.
    localparam int DEFAULT_ZERO_ADDR   = 25;
    localparam int DEFAULT_FILTER_BASE = 24;

    // Step counter width and the step numbers that shape the sequence.
    localparam int STEP_W = 5;
    localparam logic [STEP_W-1:0] LAST_STEP          = 5'd24;
    localparam logic [STEP_W-1:0] FILTER1_LAST_STEP  = 5'd10;
    localparam logic [STEP_W-1:0] INPUT_RESTART_STEP = 5'd12;
    localparam logic [STEP_W-1:0] FILTER2_START_STEP = 5'd13;
    localparam logic [STEP_W-1:0] FILTER2_LAST_STEP  = 5'd23;
    // Second input pass starts at step 12 but re-reads from address 4.
    localparam logic [STEP_W-1:0] INPUT_REWIND       = 5'd8;

    // Steps at which a finished C result can be read from the buffer.
    localparam logic [STEP_W-1:0] BUF0_STEP = 5'd10;
    localparam logic [STEP_W-1:0] BUF1_STEP = 5'd11;
    localparam logic [STEP_W-1:0] BUF2_STEP = 5'd23;
    localparam logic [STEP_W-1:0] BUF3_STEP = 5'd24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/conv_filter_addr_map.sv
// Maps filter feed index k (0..10) to a filter memory address. Every fourth
// slot is a zero bubble; the remaining slots walk down from FILTER_BASE.
module conv_filter_addr_map #(
    parameter int ADDR_W      = 8,
    parameter int ZERO_ADDR   = 25,
    parameter int FILTER_BASE = 24
) (
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(FILTER_BASE);

    // Number of real filter words already issued before slot k.
    logic [3:0] rank;
    assign rank = k - {2'b00, k[3:2]};

    // Bubble on k mod 4 == 3, otherwise descending filter address.
    always_comb begin
        if (k[1:0] == 2'b11) begin
            addr = ZERO_A;
        end else begin
            addr = BASE_A - ADDR_W'(rank);
        end
    end

endmodule

// File: rtl/conv_2by2_addr_sequencer.sv
// Drives the address/enable inputs of the 2x2 systolic convolution block
// through one 25-step sequence per accepted start. All outputs registered.
module conv_2by2_addr_sequencer
    import conv_2by2_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ZERO_ADDR   = DEFAULT_ZERO_ADDR,
    parameter int FILTER_BASE = DEFAULT_FILTER_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] input_array_addr_out,
    output logic [ADDR_W-1:0] filter_first_addr_out,
    output logic [ADDR_W-1:0] filter_second_addr_out,
    output logic [1:0]        buffer_read_addr_out,
    output logic              buffer_read_valid,
    output logic              sys_2by2_en_out,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    seq_state_t        state_reg;
    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] step_next;
    logic [STEP_W-1:0] k2_wide;
    logic [3:0]        k1;
    logic [3:0]        k2;
    logic [ADDR_W-1:0] map1_addr;
    logic [ADDR_W-1:0] map2_addr;
    logic [ADDR_W-1:0] in_addr_next;
    logic [ADDR_W-1:0] f1_addr_next;
    logic [ADDR_W-1:0] f2_addr_next;
    logic [1:0]        buf_addr_next;
    logic              buf_valid_next;

    logic [ADDR_W-1:0] in_addr_reg;
    logic [ADDR_W-1:0] f1_addr_reg;
    logic [ADDR_W-1:0] f2_addr_reg;
    logic [1:0]        buf_addr_reg;
    logic              buf_valid_reg;
    logic              en_reg;
    logic              busy_reg;
    logic              done_reg;

    // The step about to be loaded: 0 on start, otherwise the following step.
    assign step_next = (state_reg == IDLE) ? '0 : step_reg + 5'd1;
    assign k1        = step_next[3:0];
    assign k2_wide   = step_next - FILTER2_START_STEP;
    assign k2        = k2_wide[3:0];

    conv_filter_addr_map #(
        .ADDR_W      (ADDR_W),
        .ZERO_ADDR   (ZERO_ADDR),
        .FILTER_BASE (FILTER_BASE)
    ) u_map_first (
        .k    (k1),
        .addr (map1_addr)
    );

    conv_filter_addr_map #(
        .ADDR_W      (ADDR_W),
        .ZERO_ADDR   (ZERO_ADDR),
        .FILTER_BASE (FILTER_BASE)
    ) u_map_second (
        .k    (k2),
        .addr (map2_addr)
    );

    // Output values for step_next; the second filter ceiling lags the
    // input restart by one cycle to match the systolic skew.
    always_comb begin
        in_addr_next   = ZERO_A;
        f1_addr_next   = ZERO_A;
        f2_addr_next   = ZERO_A;
        buf_addr_next  = buf_addr_reg;
        buf_valid_next = 1'b0;

        if (step_next < INPUT_RESTART_STEP) begin
            in_addr_next = ADDR_W'(step_next);
        end else if (step_next < LAST_STEP) begin
            in_addr_next = ADDR_W'(step_next - INPUT_REWIND);
        end

        if (step_next <= FILTER1_LAST_STEP) begin
            f1_addr_next = map1_addr;
        end

        if (step_next >= FILTER2_START_STEP && step_next <= FILTER2_LAST_STEP) begin
            f2_addr_next = map2_addr;
        end

        case (step_next)
            BUF0_STEP: begin buf_addr_next = 2'd0; buf_valid_next = 1'b1; end
            BUF1_STEP: begin buf_addr_next = 2'd1; buf_valid_next = 1'b1; end
            BUF2_STEP: begin buf_addr_next = 2'd2; buf_valid_next = 1'b1; end
            BUF3_STEP: begin buf_addr_next = 2'd3; buf_valid_next = 1'b1; end
            default:   begin end
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            step_reg      <= '0;
            in_addr_reg   <= ZERO_A;
            f1_addr_reg   <= ZERO_A;
            f2_addr_reg   <= ZERO_A;
            buf_addr_reg  <= 2'd0;
            buf_valid_reg <= 1'b0;
            en_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    en_reg        <= 1'b0;
                    buf_valid_reg <= 1'b0;
                    if (start) begin
                        state_reg     <= RUN;
                        step_reg      <= '0;
                        in_addr_reg   <= in_addr_next;
                        f1_addr_reg   <= f1_addr_next;
                        f2_addr_reg   <= f2_addr_next;
                        buf_addr_reg  <= buf_addr_next;
                        buf_valid_reg <= buf_valid_next;
                        en_reg        <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                RUN: begin
                    if (hold) begin
                        en_reg        <= 1'b0;
                        buf_valid_reg <= 1'b0;
                    end else if (step_reg == LAST_STEP) begin
                        state_reg     <= DONE;
                        in_addr_reg   <= ZERO_A;
                        f1_addr_reg   <= ZERO_A;
                        f2_addr_reg   <= ZERO_A;
                        buf_valid_reg <= 1'b0;
                        en_reg        <= 1'b0;
                        done_reg      <= 1'b1;
                    end else begin
                        step_reg      <= step_next;
                        in_addr_reg   <= in_addr_next;
                        f1_addr_reg   <= f1_addr_next;
                        f2_addr_reg   <= f2_addr_next;
                        buf_addr_reg  <= buf_addr_next;
                        buf_valid_reg <= buf_valid_next;
                        en_reg        <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    step_reg  <= '0;
                    busy_reg  <= 1'b0;
                    en_reg    <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign input_array_addr_out   = in_addr_reg;
    assign filter_first_addr_out  = f1_addr_reg;
    assign filter_second_addr_out = f2_addr_reg;
    assign buffer_read_addr_out   = buf_addr_reg;
    assign buffer_read_valid      = buf_valid_reg;
    assign sys_2by2_en_out        = en_reg;
    assign busy                   = busy_reg;
    assign done                   = done_reg;

endmodule

// File: tb/tb_conv_2by2_addr_sequencer.sv
// Table-driven bench for the 2x2 convolution address sequencer.
module tb_conv_2by2_addr_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       hold;
    logic [7:0] input_array_addr_out;
    logic [7:0] filter_first_addr_out;
    logic [7:0] filter_second_addr_out;
    logic [1:0] buffer_read_addr_out;
    logic       buffer_read_valid;
    logic       sys_2by2_en_out;
    logic       busy;
    logic       done;

    conv_2by2_addr_sequencer #(
        .ADDR_W      (8),
        .ZERO_ADDR   (25),
        .FILTER_BASE (24)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .hold                   (hold),
        .input_array_addr_out   (input_array_addr_out),
        .filter_first_addr_out  (filter_first_addr_out),
        .filter_second_addr_out (filter_second_addr_out),
        .buffer_read_addr_out   (buffer_read_addr_out),
        .buffer_read_valid      (buffer_read_valid),
        .sys_2by2_en_out        (sys_2by2_en_out),
        .busy                   (busy),
        .done                   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int step;
        int in_a;
        int f1;
        int f2;
        int ba;
        int bv;
    } vec_t;

    vec_t tbl[25];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare outputs against table row i; frozen means hold is in effect.
    task automatic check_step(input int i, input int init_ba, input bit frozen);
        chk($sformatf("s%0d input", i), int'(input_array_addr_out), tbl[i].in_a);
        chk($sformatf("s%0d filter1", i), int'(filter_first_addr_out), tbl[i].f1);
        chk($sformatf("s%0d filter2", i), int'(filter_second_addr_out), tbl[i].f2);
        chk($sformatf("s%0d buf_addr", i), int'(buffer_read_addr_out),
            (i < 10) ? init_ba : tbl[i].ba);
        chk($sformatf("s%0d buf_valid", i), int'(buffer_read_valid), frozen ? 0 : tbl[i].bv);
        chk($sformatf("s%0d en", i), int'(sys_2by2_en_out), frozen ? 0 : 1);
        chk($sformatf("s%0d busy", i), int'(busy), 1);
        chk($sformatf("s%0d done", i), int'(done), 0);
    endtask

    task automatic check_idle_addrs(input string tag);
        chk({tag, " input"}, int'(input_array_addr_out), 25);
        chk({tag, " filter1"}, int'(filter_first_addr_out), 25);
        chk({tag, " filter2"}, int'(filter_second_addr_out), 25);
        chk({tag, " buf_valid"}, int'(buffer_read_valid), 0);
        chk({tag, " en"}, int'(sys_2by2_en_out), 0);
    endtask

    // One full sequence; returns in the first IDLE cycle after done.
    task automatic run_seq(input string name, input int init_ba, input int hold_step,
                           input int hold_len, input int restart_step, input bit start_in_done);
        int d0;
        int errs0;
        d0    = done_cnt;
        errs0 = n_err;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            check_step(i, init_ba, 1'b0);
            if (i == restart_step) start = 1'b1;
            if (i == hold_step) begin
                hold = 1'b1;
                for (int h = 0; h < hold_len; h++) begin
                    tick();
                    start = 1'b0;
                    check_step(i, init_ba, 1'b1);
                end
                hold = 1'b0;
            end
            tick();
            start = 1'b0;
        end
        chk({name, " done pulse"}, int'(done), 1);
        chk({name, " done busy"}, int'(busy), 1);
        check_idle_addrs({name, " done"});
        chk({name, " done buf_addr"}, int'(buffer_read_addr_out), 3);
        if (start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, " idle busy"}, int'(busy), 0);
        chk({name, " idle done"}, int'(done), 0);
        check_idle_addrs({name, " idle"});
        chk({name, " done count"}, done_cnt - d0, 1);
        $display("run %s: hold_step=%0d hold_len=%0d restart_step=%0d new_errors=%0d",
                 name, hold_step, hold_len, restart_step, n_err - errs0);
    endtask

    initial begin
        // step, input, filter1, filter2, buffer addr, buffer valid
        tbl[0]  = '{0,  0,  24, 25, 0, 0};
        tbl[1]  = '{1,  1,  23, 25, 0, 0};
        tbl[2]  = '{2,  2,  22, 25, 0, 0};
        tbl[3]  = '{3,  3,  25, 25, 0, 0};
        tbl[4]  = '{4,  4,  21, 25, 0, 0};
        tbl[5]  = '{5,  5,  20, 25, 0, 0};
        tbl[6]  = '{6,  6,  19, 25, 0, 0};
        tbl[7]  = '{7,  7,  25, 25, 0, 0};
        tbl[8]  = '{8,  8,  18, 25, 0, 0};
        tbl[9]  = '{9,  9,  17, 25, 0, 0};
        tbl[10] = '{10, 10, 16, 25, 0, 1};
        tbl[11] = '{11, 11, 25, 25, 1, 1};
        tbl[12] = '{12, 4,  25, 25, 1, 0};
        tbl[13] = '{13, 5,  25, 24, 1, 0};
        tbl[14] = '{14, 6,  25, 23, 1, 0};
        tbl[15] = '{15, 7,  25, 22, 1, 0};
        tbl[16] = '{16, 8,  25, 25, 1, 0};
        tbl[17] = '{17, 9,  25, 21, 1, 0};
        tbl[18] = '{18, 10, 25, 20, 1, 0};
        tbl[19] = '{19, 11, 25, 19, 1, 0};
        tbl[20] = '{20, 12, 25, 25, 1, 0};
        tbl[21] = '{21, 13, 25, 18, 1, 0};
        tbl[22] = '{22, 14, 25, 17, 1, 0};
        tbl[23] = '{23, 15, 25, 16, 2, 1};
        tbl[24] = '{24, 25, 25, 25, 3, 1};

        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        tick();
        tick();
        check_idle_addrs("reset");
        chk("reset buf_addr", int'(buffer_read_addr_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b0;
        tick();
        chk("post-reset busy", int'(busy), 0);

        // Plain run, with a start pulse in the DONE cycle that must be ignored.
        run_seq("plain", 0, -1, 0, -1, 1'b1);
        tick();
        chk("ignored done-start busy", int'(busy), 0);
        tick();

        // Hold for three cycles at step 6.
        run_seq("hold", 3, 6, 3, -1, 1'b0);
        tick();

        // Start re-pulsed mid-run, then an immediate back-to-back run.
        run_seq("restart", 3, -1, 0, 5, 1'b0);
        run_seq("back2back", 3, -1, 0, -1, 1'b0);
        tick();

        // Reset at step 15, with start held alongside it.
        begin
            int d0;
            d0    = done_cnt;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 16; i++) begin
                check_step(i, 3, 1'b0);
                if (i < 15) tick();
            end
            rst   = 1'b1;
            start = 1'b1;
            tick();
            check_idle_addrs("midrst");
            chk("midrst buf_addr", int'(buffer_read_addr_out), 0);
            chk("midrst busy", int'(busy), 0);
            chk("midrst done", int'(done), 0);
            rst   = 1'b0;
            start = 1'b0;
            tick();
            chk("midrst start ignored busy", int'(busy), 0);
            tick();
            tick();
            chk("midrst no done", done_cnt - d0, 0);
            $display("run midrst: reset at step 15, done_delta=%0d", done_cnt - d0);
        end

        run_seq("after-reset", 0, -1, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
